branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  IF-stage dynamic branch predictor: a direct-mapped BTB plus 2-bit saturating counters.
//  - IF side: looks up the fetch PC and supplies predicted direction and next fetch PC.
//  - ID side: takes the resolved outcome from the ID branch-test logic, updates the tables
//    and flags mispredicts.
//  - On a mispredict it supplies the redirect PC for the IF/ID flush.
// PARAMETERS
//  IDX_BITS   4   table index width; ENTRIES = 2**IDX_BITS
//  GHR_BITS   4   global history width (used only with BP_GSHARE_EN; must be <= IDX_BITS)
// PORTS
//  clk              in   1   clock, rising edge
//  rst_n            in   1   async reset, active low
//  if_pc            in   32  fetch PC
//  if_pred_taken    out  1   predicted taken for if_pc
//  if_pred_target   out  32  predicted next fetch PC
//  if_ghr           out  GHR_BITS  history snapshot to carry down the pipe with the instr
//  id_valid         in   1   ID holds a real (unflushed) SB-type instr
//  id_pc            in   32  PC of the ID instr
//  id_taken         in   1   resolved direction from the branch test
//  id_target        in   32  resolved branch target (pc + imm)
//  id_pred_taken    in   1   prediction carried with the instr from IF
//  id_pred_target   in   32  predicted target carried with the instr from IF
//  id_ghr           in   GHR_BITS  if_ghr carried with the instr from IF
//  id_mispredict    out  1   flush request
//  id_redirect_pc   out  32  correct next PC
// BEHAVIOUR
//  - Address split: idx = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2]; pc[1:0] ignored.
//  - Per entry: valid, tag, target[31:0], ctr[1:0].
//    ctr encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//  - Reset (async, any time): all valid=0, ctr=01, ghr=0, stats=0.
//    Outputs then read if_pred_taken=0, if_pred_target=if_pc+4, id_mispredict=0.
//  - Lookup is combinational on registered state (0-cycle latency).
//    hit = valid[idx] && tag[idx]==tag(if_pc).
//    if_pred_taken = hit && ctr[1].
//    if_pred_target = if_pred_taken ? target[idx] : if_pc+4 (32-bit, wraps mod 2**32).
//  - Update at the clk edge, only when id_valid=1:
//    * hit, taken: ctr++ (saturate at 11), target <= id_target.
//    * hit, not taken: ctr-- (saturate at 00), target unchanged.
//    * miss, taken: allocate; valid=1, tag and target written, ctr=10; evicts any alias.
//    * miss, not taken: no change.
//    * id_valid=0: no state change.
//  - Same-cycle lookup and update of the same entry: lookup sees the pre-update value (no bypass).
//  - Mispredict (combinational):
//    id_mispredict = id_valid && (id_taken!=id_pred_taken || (id_taken && id_pred_target!=id_target)).
//    id_redirect_pc = id_taken ? id_target : id_pc+4; valid only while id_mispredict=1.
//  - No stall input: the caller deasserts id_valid on bubbles and flushed slots.
// CONFIGURATION
//  - BP_GSHARE_EN defined:
//    * ctr array becomes a separate PHT indexed by idx ^ {ghr, zero-extended to IDX_BITS}.
//    * BTB valid/tag/target stays PC-indexed.
//    * Lookup uses the current ghr; update uses id_ghr to form the PHT index.
//    * ghr <= {ghr[GHR_BITS-2:0], id_taken} on each id_valid.
//    * On id_mispredict, ghr is repaired to {id_ghr[GHR_BITS-2:0], id_taken}.
//    * if_ghr = ghr.
//  - BP_GSHARE_EN undefined: pure bimodal; the PHT shares idx; no ghr register.
//    if_ghr ties to 0 and id_ghr is ignored.
// TESTING
//  1. Reset, if_pc=0x100 -> if_pred_taken=0, if_pred_target=0x104.
//     Pulse rst_n low mid-run -> same result immediately, without a clk edge.
//  2. id_valid=1, id_pc=0x100, id_taken=1, id_target=0x80, id_pred_taken=0
//     -> id_mispredict=1, redirect=0x80.
//     Next cycle if_pc=0x100 -> pred_taken=1, target=0x80.
//  3. Hysteresis: 0x100 with ctr=10, update not-taken -> ctr=01, predicts NT.
//     3x taken -> ctr=11; 1x not-taken -> still predicts T.
//  4. Alias: IDX_BITS=4, allocate 0x100 taken, then look up 0x140 -> tag miss, pred_taken=0.
//     Allocate 0x140 taken -> 0x100 lookup now misses.
//  5. Same cycle: if_pc=0x100 lookup while id updates 0x100 taken->NT -> lookup returns old prediction.
//     id_taken=1, pred target 0x80 vs actual 0x90 -> id_mispredict=1, redirect=0x90.
//  6. BP_GSHARE_EN: taken pattern T,N,T,N at 0x200, id_ghr carried correctly
//     -> after warm-up, zero mispredicts over 8 iterations.
//     Bimodal build mispredicts >= 4 of the same 8.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_predictor                                                           |
// | Direct-mapped BTB with 2-bit counters; optional gshare PHT (BP_GSHARE_EN). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_predictor #(
   parameter int IDX_BITS = 4,
   parameter int GHR_BITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         if_pc,
   output logic                if_pred_taken,
   output logic [31:0]         if_pred_target,
   output logic [GHR_BITS-1:0] if_ghr,
   input  logic                id_valid,
   input  logic [31:0]         id_pc,
   input  logic                id_taken,
   input  logic [31:0]         id_target,
   input  logic                id_pred_taken,
   input  logic [31:0]         id_pred_target,
   input  logic [GHR_BITS-1:0] id_ghr,
   output logic                id_mispredict,
   output logic [31:0]         id_redirect_pc
);

   localparam int ENTRIES  = 2**IDX_BITS;
   localparam int TAG_BITS = 30 - IDX_BITS;

   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];

   logic [IDX_BITS-1:0] w_if_idx, w_id_idx, w_if_pht_idx, w_id_pht_idx;
   logic [TAG_BITS-1:0] w_if_tag, w_id_tag;
   logic                w_if_hit, w_id_hit;
   logic [1:0]          w_id_ctr, w_ctr_inc, w_ctr_dec;

   assign w_if_idx = if_pc[IDX_BITS+1:2];
   assign w_if_tag = if_pc[31:IDX_BITS+2];
   assign w_id_idx = id_pc[IDX_BITS+1:2];
   assign w_id_tag = id_pc[31:IDX_BITS+2];

`ifdef BP_GSHARE_EN
   logic [GHR_BITS-1:0] ghr_q, ghr_d;

   // Prediction indexes with live history; training uses the history the instr saw at fetch.
   assign w_if_pht_idx = w_if_idx ^ IDX_BITS'(ghr_q);
   assign w_id_pht_idx = w_id_idx ^ IDX_BITS'(id_ghr);
   assign if_ghr       = ghr_q;

   always_comb begin
      ghr_d = ghr_q;
      if (id_valid) begin
         if (id_mispredict) ghr_d = {id_ghr[GHR_BITS-2:0], id_taken};
         else               ghr_d = {ghr_q[GHR_BITS-2:0], id_taken};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ghr_q <= '0;
      else        ghr_q <= ghr_d;
   end
`else
   logic w_unused_ghr;

   assign w_if_pht_idx = w_if_idx;
   assign w_id_pht_idx = w_id_idx;
   assign if_ghr       = '0;
   assign w_unused_ghr = ^id_ghr;
`endif

   assign w_if_hit       = valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);
   assign if_pred_taken  = w_if_hit && ctr_q[w_if_pht_idx][1];
   assign if_pred_target = if_pred_taken ? target_q[w_if_idx] : if_pc + 32'd4;

   assign w_id_hit  = valid_q[w_id_idx] && (tag_q[w_id_idx] == w_id_tag);
   assign w_id_ctr  = ctr_q[w_id_pht_idx];
   assign w_ctr_inc = (w_id_ctr == 2'b11) ? w_id_ctr : w_id_ctr + 2'd1;
   assign w_ctr_dec = (w_id_ctr == 2'b00) ? w_id_ctr : w_id_ctr - 2'd1;

   assign id_mispredict  = id_valid && ((id_taken != id_pred_taken) ||
                                        (id_taken && (id_pred_target != id_target)));
   assign id_redirect_pc = id_taken ? id_target : id_pc + 32'd4;

   // A taken miss claims the slot outright, evicting whichever PC aliased there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (id_valid) begin
         if (w_id_hit) begin
            if (id_taken) begin
               ctr_q[w_id_pht_idx] <= w_ctr_inc;
               target_q[w_id_idx]  <= id_target;
            end else begin
               ctr_q[w_id_pht_idx] <= w_ctr_dec;
            end
         end else if (id_taken) begin
            valid_q[w_id_idx]   <= 1'b1;
            tag_q[w_id_idx]     <= w_id_tag;
            target_q[w_id_idx]  <= id_target;
            ctr_q[w_id_pht_idx] <= 2'b10;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_predictor                                                        |
// | Directed self-checking bench for branch_predictor.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_branch_predictor;

   localparam int GHR_BITS = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [31:0]         if_pc;
   logic                if_pred_taken;
   logic [31:0]         if_pred_target;
   logic [GHR_BITS-1:0] if_ghr;
   logic                id_valid;
   logic [31:0]         id_pc;
   logic                id_taken;
   logic [31:0]         id_target;
   logic                id_pred_taken;
   logic [31:0]         id_pred_target;
   logic [GHR_BITS-1:0] id_ghr;
   logic                id_mispredict;
   logic [31:0]         id_redirect_pc;

   int n_pass  = 0;
   int n_total = 0;

   branch_predictor #(.IDX_BITS(4), .GHR_BITS(GHR_BITS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_pc          (if_pc),
      .if_pred_taken  (if_pred_taken),
      .if_pred_target (if_pred_target),
      .if_ghr         (if_ghr),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_taken       (id_taken),
      .id_target      (id_target),
      .id_pred_taken  (id_pred_taken),
      .id_pred_target (id_pred_target),
      .id_ghr         (id_ghr),
      .id_mispredict  (id_mispredict),
      .id_redirect_pc (id_redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic id_set(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
      id_valid       = v;
      id_pc          = pc;
      id_taken       = tk;
      id_target      = tgt;
      id_pred_taken  = ptk;
      id_pred_target = ptgt;
      id_ghr         = '0;
   endtask

   // Resolve one branch in ID over a single clock edge.
   task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      @(negedge clk);
      id_set(1'b1, pc, tk, tgt, 1'b0, pc + 32'd4);
      @(posedge clk);
      #1 id_set(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      id_set(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #2 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      if_pc  = 32'h100;
      id_set(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      n_total++;
      if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h104) $display("FAIL reset_lookup: got %b/%h want 0/00000104", if_pred_taken, if_pred_target);
      else n_pass++;
      n_total++;
      if (id_mispredict !== 1'b0 || if_ghr !== 4'h0) $display("FAIL reset_misc: mispredict=%b ghr=%h want 0/0", id_mispredict, if_ghr);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_allocate();
      @(negedge clk);
      if_pc = 32'h100;
      id_set(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      #1;
      n_total++;
      if (id_mispredict !== 1'b1 || id_redirect_pc !== 32'h80) $display("FAIL alloc_mispredict: got %b/%h want 1/00000080", id_mispredict, id_redirect_pc);
      else n_pass++;
      @(posedge clk);
      #1 id_set(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      n_total++;
      if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h80) $display("FAIL alloc_lookup: got %b/%h want 1/00000080", if_pred_taken, if_pred_target);
      else n_pass++;
   endtask

   task automatic test_hysteresis();
      @(negedge clk);
      if_pc = 32'h100;
      id_set(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      #1;
      n_total++;
      if (id_mispredict !== 1'b1 || id_redirect_pc !== 32'h104) $display("FAIL nt_redirect: got %b/%h want 1/00000104", id_mispredict, id_redirect_pc);
      else n_pass++;
      @(posedge clk);
      #1 id_set(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      n_total++;
      if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h104) $display("FAIL weak_nt: got %b/%h want 0/00000104", if_pred_taken, if_pred_target);
      else n_pass++;
      repeat (3) resolve(32'h100, 1'b1, 32'h80);
      resolve(32'h100, 1'b0, 32'h80);
      #1;
      n_total++;
      if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h80) $display("FAIL strong_t_hold: got %b/%h want 1/00000080", if_pred_taken, if_pred_target);
      else n_pass++;
      resolve(32'h100, 1'b0, 32'h80);
      #1;
      n_total++;
      if (if_pred_taken !== 1'b0) $display("FAIL second_nt: got %b want 0", if_pred_taken);
      else n_pass++;
   endtask

   task automatic test_alias();
      resolve(32'h100, 1'b1, 32'h80);
      @(negedge clk);
      if_pc = 32'h140;
      #1;
      n_total++;
      if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h144) $display("FAIL alias_miss: got %b/%h want 0/00000144", if_pred_taken, if_pred_target);
      else n_pass++;
      resolve(32'h140, 1'b1, 32'h300);
      if_pc = 32'h100;
      #1;
      n_total++;
      if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h104) $display("FAIL alias_evict: got %b/%h want 0/00000104", if_pred_taken, if_pred_target);
      else n_pass++;
      if_pc = 32'h140;
      #1;
      n_total++;
      if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h300) $display("FAIL alias_new: got %b/%h want 1/00000300", if_pred_taken, if_pred_target);
      else n_pass++;
   endtask

   task automatic test_same_cycle();
      resolve(32'h100, 1'b1, 32'h80);
      @(negedge clk);
      if_pc = 32'h100;
      id_set(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      #1;
      n_total++;
      if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h80) $display("FAIL same_cycle_old: got %b/%h want 1/00000080", if_pred_taken, if_pred_target);
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if (if_pred_taken !== 1'b0) $display("FAIL same_cycle_new: got %b want 0", if_pred_taken);
      else n_pass++;
      @(negedge clk);
      id_set(1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
      #1;
      n_total++;
      if (id_mispredict !== 1'b1 || id_redirect_pc !== 32'h90) $display("FAIL target_mismatch: got %b/%h want 1/00000090", id_mispredict, id_redirect_pc);
      else n_pass++;
      id_set(1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h90);
      #1;
      n_total++;
      if (id_mispredict !== 1'b0) $display("FAIL correct_taken: got %b want 0", id_mispredict);
      else n_pass++;
      id_set(1'b1, 32'h100, 1'b0, 32'h90, 1'b0, 32'h55);
      #1;
      n_total++;
      if (id_mispredict !== 1'b0) $display("FAIL correct_nt: got %b want 0", id_mispredict);
      else n_pass++;
      id_set(1'b0, 32'h180, 1'b1, 32'h400, 1'b0, 32'h184);
      #1;
      n_total++;
      if (id_mispredict !== 1'b0) $display("FAIL invalid_no_flush: got %b want 0", id_mispredict);
      else n_pass++;
      @(posedge clk);
      #1 id_set(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      if_pc = 32'h180;
      #1;
      n_total++;
      if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h184) $display("FAIL invalid_no_update: got %b/%h want 0/00000184", if_pred_taken, if_pred_target);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      resolve(32'h100, 1'b1, 32'h80);
      @(negedge clk);
      if_pc = 32'h100;
      #1;
      n_total++;
      if (if_pred_taken !== 1'b1) $display("FAIL pre_async: got %b want 1", if_pred_taken);
      else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_total++;
      if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h104) $display("FAIL async_reset: got %b/%h want 0/00000104", if_pred_taken, if_pred_target);
      else n_pass++;
      #1 rst_n = 1'b1;
      if_pc = 32'hFFFF_FFFC;
      #1;
      n_total++;
      if (if_pred_target !== 32'h0) $display("FAIL pc_wrap: got %h want 00000000", if_pred_target);
      else n_pass++;
   endtask

   task automatic test_gshare_pattern();
      logic                p;
      logic [31:0]         t;
      logic [GHR_BITS-1:0] g;
      logic                tk;
      int                  misses;
      misses = 0;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         tk = (i % 2 == 0);
         @(negedge clk);
         id_valid = 1'b0;
         if_pc    = 32'h200;
         #1;
         p = if_pred_taken;
         t = if_pred_target;
         g = if_ghr;
         id_set(1'b1, 32'h200, tk, 32'h400, p, t);
         id_ghr = g;
         #1;
         if (i >= 8 && id_mispredict) misses++;
         @(posedge clk);
         #1 id_set(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      end
      n_total++;
`ifdef BP_GSHARE_EN
      if (misses != 0) $display("FAIL gshare_pattern: mispredicts=%0d want 0", misses);
      else n_pass++;
`else
      if (misses < 4) $display("FAIL bimodal_pattern: mispredicts=%0d want >=4", misses);
      else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_hysteresis();
      test_alias();
      test_same_cycle();
      test_async_reset();
      test_gshare_pattern();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
